// File: rtl/mmc1_serial_writer_if.sv
// ----------------------------------------------------------------------------
// mmc1_serial_writer_if: command, CPU-bus and shadow-read signals of the writer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mmc1_serial_writer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_reg;
  logic [4:0] cmd_data;
  logic       cmd_rst;
  logic       busy;
  logic       done;
  logic       cpu_m2;
  logic       cpu_rw;
  logic       cpu_ce_n;
  logic [1:0] cpu_addr;
  logic       cpu_d7;
  logic       cpu_d0;
  logic [1:0] sh_sel;
  logic [4:0] sh_dat;

  modport master (
    input  cmd_valid, cmd_reg, cmd_data, cmd_rst, sh_sel,
    output cmd_ready, busy, done, cpu_m2, cpu_rw, cpu_ce_n, cpu_addr,
           cpu_d7, cpu_d0, sh_dat
  );

  modport slave (
    output cmd_valid, cmd_reg, cmd_data, cmd_rst, sh_sel,
    input  cmd_ready, busy, done, cpu_m2, cpu_rw, cpu_ce_n, cpu_addr,
           cpu_d7, cpu_d0, sh_dat
  );
endinterface

`default_nettype wire

// File: rtl/mmc1_serial_writer.sv
// ----------------------------------------------------------------------------
// mmc1_serial_writer: emits MMC1 serial-load CPU writes; shadow regs via MMC1W_SHADOW_EN
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mmc1_serial_writer #(
  parameter int M2_DIV  = 6,
  parameter int GAP_CYC = 1
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  mmc1_serial_writer_if.master bus
);

  localparam int              PH_W     = $clog2(2 * M2_DIV);
  localparam logic [PH_W-1:0] PH_RISE  = PH_W'(M2_DIV - 1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * M2_DIV - 1);
  localparam int              GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_GAP   = 3'd2,
    S_RSTW  = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  logic [PH_W-1:0]  phase_q, phase_d;
  logic             m2_q;
  logic             cycle_end;

  state_t           state_q;
  logic             busy_q, done_q;
  logic             rw_q, ce_n_q, d7_q, d0_q;
  logic [1:0]       addr_q;
  logic [1:0]       reg_q;
  logic [4:0]       data_q;
  logic             rst_q;
  logic [2:0]       bit_q;
  logic [GAP_W-1:0] gap_q;

  // M2 free-runs: LO for M2_DIV clks, then HI; cycle_end is the last HI clk.
  assign cycle_end = (phase_q == PH_LAST);
  assign phase_d   = cycle_end ? '0 : phase_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      m2_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (cycle_end)
        m2_q <= 1'b0;
      else if (phase_q == PH_RISE)
        m2_q <= 1'b1;
    end
  end

  // Bus outputs change only on the M2 falling edge, so each cycle is stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rw_q    <= 1'b1;
      ce_n_q  <= 1'b1;
      addr_q  <= 2'd0;
      d7_q    <= 1'b0;
      d0_q    <= 1'b0;
      reg_q   <= 2'd0;
      data_q  <= 5'd0;
      rst_q   <= 1'b0;
      bit_q   <= 3'd0;
      gap_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            reg_q   <= bus.cmd_reg;
            data_q  <= bus.cmd_data;
            rst_q   <= bus.cmd_rst;
            bit_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= S_ARM;
          end
        end
        S_ARM: begin
          if (cycle_end) begin
            gap_q   <= GAP_INIT;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (cycle_end) begin
            if (gap_q != '0) begin
              gap_q <= gap_q - 1'b1;
            end else begin
              rw_q   <= 1'b0;
              ce_n_q <= 1'b0;
              addr_q <= reg_q;
              if (rst_q) begin
                d7_q    <= 1'b1;
                d0_q    <= 1'b0;
                state_q <= S_RSTW;
              end else begin
                d7_q    <= 1'b0;
                d0_q    <= data_q[bit_q];
                state_q <= S_WRITE;
              end
            end
          end
        end
        S_RSTW: begin
          if (cycle_end) begin
            rst_q   <= 1'b0;
            rw_q    <= 1'b1;
            ce_n_q  <= 1'b1;
            d7_q    <= 1'b0;
            d0_q    <= 1'b0;
            gap_q   <= GAP_INIT;
            state_q <= S_GAP;
          end
        end
        S_WRITE: begin
          if (cycle_end) begin
            rw_q   <= 1'b1;
            ce_n_q <= 1'b1;
            d7_q   <= 1'b0;
            d0_q   <= 1'b0;
            if (bit_q == 3'd4) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_FIN;
            end else begin
              bit_q   <= bit_q + 3'd1;
              gap_q   <= GAP_INIT;
              state_q <= S_GAP;
            end
          end
        end
        // The FIN bus cycle is already idle; only one clk of not-ready is needed.
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cpu_m2    = m2_q;
  assign bus.cpu_rw    = rw_q;
  assign bus.cpu_ce_n  = ce_n_q;
  assign bus.cpu_addr  = addr_q;
  assign bus.cpu_d7    = d7_q;
  assign bus.cpu_d0    = d0_q;

`ifdef MMC1W_SHADOW_EN
  logic [4:0] shadow_q [4];

  // A reset write forces control[3:2]=11 whatever register it addressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q[0] <= 5'h1F;
      shadow_q[1] <= 5'h00;
      shadow_q[2] <= 5'h00;
      shadow_q[3] <= 5'h00;
    end else if (cycle_end) begin
      if (state_q == S_RSTW)
        shadow_q[0][3:2] <= 2'b11;
      if (state_q == S_WRITE && bit_q == 3'd4)
        shadow_q[reg_q] <= data_q;
    end
  end

  assign bus.sh_dat = shadow_q[bus.sh_sel];
`else
  logic unused_sh_sel;
  assign unused_sh_sel = ^bus.sh_sel;
  assign bus.sh_dat    = 5'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mmc1_serial_writer.sv
// ----------------------------------------------------------------------------
// tb_mmc1_serial_writer: randomized bench with bus monitor and behavioural MMC1 receiver
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mmc1_serial_writer;

  localparam int M2_DIV  = 2;
  localparam int GAP_CYC = 1;

  typedef struct packed {
    logic       rw;
    logic       ce_n;
    logic [1:0] addr;
    logic       d7;
    logic       d0;
  } cyc_t;

  localparam cyc_t IDLE_C = cyc_t'(6'b11_00_00);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mmc1_serial_writer_if ifa ();
  mmc1_serial_writer_if ifb ();

  mmc1_serial_writer #(.M2_DIV(M2_DIV), .GAP_CYC(GAP_CYC)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.master)
  );
  mmc1_serial_writer #(.M2_DIV(1), .GAP_CYC(GAP_CYC)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.master)
  );

  int errors = 0;
  int checks = 0;

  // Bus monitor and MMC1 receiver model.
  cyc_t       mon_q [$];
  cyc_t       cur, last_hi, ref_c;
  bit         mon_prev, have_ref, rx_prev_w;
  int         unstable, consec, rx_cnt;
  logic [4:0] rx_sr;
  logic [4:0] rx_reg [4];
  logic [4:0] exp_rx [4];
  logic [4:0] exp_sh [4];

  int   r_lat, r_serr;
  bit   r_to, r_acc, r_post;

  always @(negedge clk) begin
    cur = cyc_t'({ifa.cpu_rw, ifa.cpu_ce_n, ifa.cpu_addr, ifa.cpu_d7, ifa.cpu_d0});
    if (!rst_n) begin
      mon_prev = 1'b0;
      have_ref = 1'b0;
    end else begin
      if (mon_prev && !ifa.cpu_m2) begin
        mon_q.push_back(last_hi);
        if (!last_hi.rw && !last_hi.ce_n) begin
          if (rx_prev_w) consec++;
          else if (last_hi.d7) begin
            rx_cnt    = 0;
            rx_sr     = 5'd0;
            rx_reg[0] = rx_reg[0] | 5'h0C;
          end else begin
            rx_sr = {last_hi.d0, rx_sr[4:1]};
            rx_cnt++;
            if (rx_cnt == 5) begin
              rx_reg[last_hi.addr] = rx_sr;
              rx_cnt = 0;
            end
          end
          rx_prev_w = 1'b1;
        end else begin
          rx_prev_w = 1'b0;
        end
        ref_c    = cur;
        have_ref = 1'b1;
      end else if (!have_ref) begin
        ref_c    = cur;
        have_ref = 1'b1;
      end else if (cur !== ref_c) begin
        unstable++;
      end
      if (ifa.cpu_m2) last_hi = cur;
      mon_prev = ifa.cpu_m2;
    end
  end

  function automatic int exp_lat(int div, bit rs);
    return 2 * div * (GAP_CYC + 1) * (5 + int'(rs));
  endfunction

  task automatic shadow_reset_model();
    exp_sh[0] = 5'h1F; exp_sh[1] = 5'h00; exp_sh[2] = 5'h00; exp_sh[3] = 5'h00;
  endtask

  // Drives one command on DUT A and measures it; results land in r_* variables.
  task automatic run_cmd(input logic [1:0] r, input logic [4:0] d, input bit rs,
                         input bit hold, input logic [4:0] after_d);
    int   n;
    bit   prev_m2, started;
    cyc_t e [$];
    cyc_t a;
    int   base;
    r_to = 1'b0; r_acc = 1'b0; r_post = 1'b0; r_lat = 0; r_serr = 0;
    @(negedge clk);
    ifa.cmd_valid = 1'b1; ifa.cmd_reg = r; ifa.cmd_data = d; ifa.cmd_rst = rs;
    n = 0;
    do begin @(negedge clk); n++; end while (!ifa.busy && n < 200);
    if (!ifa.busy) begin
      ifa.cmd_valid = 1'b0;
      r_to = 1'b1;
      return;
    end
    r_acc = (ifa.cmd_ready === 1'b0);
    ifa.cmd_valid = hold;
    ifa.cmd_data  = after_d;
    if (!hold) begin
      ifa.cmd_reg = 2'($urandom);
      ifa.cmd_rst = 1'($urandom);
    end
    prev_m2 = ifa.cpu_m2; started = 1'b0; n = 0;
    forever begin
      @(negedge clk); n++;
      if (started) r_lat++;
      else if (prev_m2 && !ifa.cpu_m2) started = 1'b1;
      prev_m2 = ifa.cpu_m2;
      if (ifa.done === 1'b1 || n > 5000) break;
    end
    r_to = (ifa.done !== 1'b1);
    @(negedge clk);
    r_post = (ifa.cmd_ready === 1'b1) && (ifa.done === 1'b0) && (ifa.busy === 1'b0);
    e.push_back(IDLE_C);
    if (rs) begin
      repeat (GAP_CYC) e.push_back(IDLE_C);
      e.push_back(cyc_t'({1'b0, 1'b0, r, 1'b1, 1'b0}));
    end
    for (int k = 0; k < 5; k++) begin
      repeat (GAP_CYC) e.push_back(IDLE_C);
      e.push_back(cyc_t'({1'b0, 1'b0, r, 1'b0, d[k]}));
    end
    if (mon_q.size() < e.size()) r_serr = e.size();
    else begin
      base = mon_q.size() - e.size();
      foreach (e[i]) begin
        a = mon_q[base + i];
        if (a.rw !== e[i].rw || a.ce_n !== e[i].ce_n || a.d7 !== e[i].d7 ||
            a.d0 !== e[i].d0 || (!e[i].rw && a.addr !== e[i].addr))
          r_serr++;
      end
    end
    mon_q.delete();
    if (!r_to) begin
      if (rs) begin
        exp_rx[0] = exp_rx[0] | 5'h0C;
        exp_sh[0] = exp_sh[0] | 5'h0C;
      end
      exp_rx[r] = d;
      exp_sh[r] = d;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ifa.cpu_m2, ifa.cpu_rw, ifa.cpu_ce_n, ifa.cpu_addr, ifa.cpu_d7, ifa.cpu_d0,
         ifa.busy, ifa.done, ifa.cmd_ready} !== 10'b0_1_1_00_0_0_0_0_1) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0110000001",
               {ifa.cpu_m2, ifa.cpu_rw, ifa.cpu_ce_n, ifa.cpu_addr, ifa.cpu_d7,
                ifa.cpu_d0, ifa.busy, ifa.done, ifa.cmd_ready});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({ifa.cpu_rw, ifa.cpu_ce_n, ifa.busy, ifa.cmd_ready} !== 4'b1101) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 1101",
               {ifa.cpu_rw, ifa.cpu_ce_n, ifa.busy, ifa.cmd_ready});
    end
    for (int i = 0; i < 4; i++) begin
      ifa.sh_sel = 2'(i);
      #1;
      checks++;
`ifdef MMC1W_SHADOW_EN
      if (ifa.sh_dat !== exp_sh[i]) begin
        errors++;
        $display("FAIL shadow_reset[%0d]: got %h want %h", i, ifa.sh_dat, exp_sh[i]);
      end
`else
      if (ifa.sh_dat !== 5'd0) begin
        errors++;
        $display("FAIL shadow_off[%0d]: got %h want 00", i, ifa.sh_dat);
      end
`endif
    end
  endtask

  task automatic test_sequence();
    run_cmd(2'd3, 5'b10110, 1'b1, 1'b0, 5'($urandom));
    checks++;
    if (r_to || !r_acc) begin
      errors++;
      $display("FAIL seq_handshake: got timeout=%0d accepted=%0d want 0 1", r_to, r_acc);
    end
    checks++;
    if (r_lat !== 48) begin
      errors++;
      $display("FAIL seq_latency: got %0d clks want 48", r_lat);
    end
    checks++;
    if (!r_post) begin
      errors++;
      $display("FAIL seq_done_pulse: ready/done/busy after done wrong, want 1/0/0");
    end
    checks++;
    if (r_serr !== 0) begin
      errors++;
      $display("FAIL seq_bus_cycles: got %0d bad cycles want 0", r_serr);
    end
    checks++;
    if (rx_reg[3] !== 5'b10110) begin
      errors++;
      $display("FAIL seq_rx_prg: got %h want 16", rx_reg[3]);
    end
  endtask

  task automatic test_receiver();
    logic [4:0] vals [4];
    vals[0] = 5'h0E; vals[1] = 5'h13; vals[2] = 5'h05; vals[3] = 5'h1A;
    for (int i = 0; i < 4; i++) begin
      run_cmd(2'(i), vals[i], 1'b0, 1'b0, 5'($urandom));
      checks++;
      if (r_to || r_serr !== 0) begin
        errors++;
        $display("FAIL rx_cmd[%0d]: got timeout=%0d bad=%0d want 0 0", i, r_to, r_serr);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_reg[i] !== vals[i]) begin
        errors++;
        $display("FAIL rx_reg[%0d]: got %h want %h", i, rx_reg[i], vals[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    run_cmd(2'd2, 5'h01, 1'b0, 1'b1, 5'h02);
    checks++;
    if (r_to || !r_post || r_serr !== 0) begin
      errors++;
      $display("FAIL b2b_first: got timeout=%0d post=%0d bad=%0d want 0 1 0", r_to, r_post, r_serr);
    end
    checks++;
    if (rx_reg[2] !== 5'h01) begin
      errors++;
      $display("FAIL b2b_first_value: got %h want 01", rx_reg[2]);
    end
    @(negedge clk);
    checks++;
    if (ifa.busy !== 1'b1 || ifa.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_accept: got busy=%b ready=%b want 1 0", ifa.busy, ifa.cmd_ready);
    end
    ifa.cmd_valid = 1'b0;
    ifa.cmd_data  = 5'($urandom);
    n = 0;
    while (ifa.done !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    @(negedge clk);
    exp_rx[2] = 5'h02; exp_sh[2] = 5'h02;
    mon_q.delete();
    checks++;
    if (rx_reg[2] !== 5'h02) begin
      errors++;
      $display("FAIL b2b_second_value: got %h want 02", rx_reg[2]);
    end
  endtask

  task automatic test_reset_mid();
    int n, w;
    bit prev;
    @(negedge clk);
    ifa.cmd_valid = 1'b1; ifa.cmd_reg = 2'd1; ifa.cmd_data = 5'($urandom); ifa.cmd_rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ifa.busy && n < 100);
    ifa.cmd_valid = 1'b0;
    prev = ifa.cpu_rw; w = 0; n = 0;
    while (w < 3 && n < 2000) begin
      @(negedge clk); n++;
      if (prev && !ifa.cpu_rw) w++;
      prev = ifa.cpu_rw;
    end
    checks++;
    if (w != 3) begin
      errors++;
      $display("FAIL mid_reach_write2: got %0d writes want 3", w);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ifa.cpu_m2, ifa.cpu_rw, ifa.cpu_ce_n, ifa.cpu_addr, ifa.cpu_d7, ifa.cpu_d0,
         ifa.busy, ifa.done, ifa.cmd_ready} !== 10'b0_1_1_00_0_0_0_0_1) begin
      errors++;
      $display("FAIL mid_async_reset: got %b want 0110000001",
               {ifa.cpu_m2, ifa.cpu_rw, ifa.cpu_ce_n, ifa.cpu_addr, ifa.cpu_d7,
                ifa.cpu_d0, ifa.busy, ifa.done, ifa.cmd_ready});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    shadow_reset_model();
    mon_q.delete();
    run_cmd(2'd3, 5'h07, 1'b1, 1'b0, 5'($urandom));
    checks++;
    if (r_to || r_serr !== 0 || r_lat !== exp_lat(M2_DIV, 1'b1)) begin
      errors++;
      $display("FAIL mid_resync_cmd: got timeout=%0d bad=%0d lat=%0d want 0 0 %0d",
               r_to, r_serr, r_lat, exp_lat(M2_DIV, 1'b1));
    end
    checks++;
    if (rx_reg[3] !== 5'h07) begin
      errors++;
      $display("FAIL mid_resync_value: got %h want 07", rx_reg[3]);
    end
  endtask

  task automatic test_random();
    logic [1:0] r;
    logic [4:0] d;
    bit         rs;
    for (int i = 0; i < 8; i++) begin
      r  = 2'($urandom_range(0, 3));
      d  = 5'($urandom);
      rs = 1'($urandom);
      run_cmd(r, d, rs, 1'b0, 5'($urandom));
      checks++;
      if (r_to || r_serr !== 0 || r_lat !== exp_lat(M2_DIV, rs) || !r_post) begin
        errors++;
        $display("FAIL rand_cmd[%0d]: got timeout=%0d bad=%0d lat=%0d post=%0d want 0 0 %0d 1",
                 i, r_to, r_serr, r_lat, r_post, exp_lat(M2_DIV, rs));
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_reg[i] !== exp_rx[i]) begin
        errors++;
        $display("FAIL rand_rx[%0d]: got %h want %h", i, rx_reg[i], exp_rx[i]);
      end
    end
  endtask

  task automatic test_fast();
    int   n, lat, tog_err, pat_err, werr;
    bit   prev, started;
    logic rwq [$];
    @(negedge clk);
    ifb.cmd_valid = 1'b1; ifb.cmd_reg = 2'd1; ifb.cmd_data = 5'h1F; ifb.cmd_rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ifb.busy && n < 100);
    ifb.cmd_valid = 1'b0;
    prev = ifb.cpu_m2; started = 1'b0; lat = 0; tog_err = 0; werr = 0; n = 0;
    forever begin
      @(negedge clk); n++;
      if (started) begin
        lat++;
        if (ifb.cpu_m2 === prev) tog_err++;
        if (ifb.cpu_m2 === 1'b1) begin
          rwq.push_back(ifb.cpu_rw);
          if (!ifb.cpu_rw && (ifb.cpu_d0 !== 1'b1 || ifb.cpu_addr !== 2'd1 || ifb.cpu_ce_n !== 1'b0))
            werr++;
        end
      end else if (prev && !ifb.cpu_m2) started = 1'b1;
      prev = ifb.cpu_m2;
      if (ifb.done === 1'b1 || n > 1000) break;
    end
    checks++;
    if (ifb.done !== 1'b1 || lat !== exp_lat(1, 1'b0)) begin
      errors++;
      $display("FAIL fast_latency: got done=%b lat=%0d want 1 %0d", ifb.done, lat, exp_lat(1, 1'b0));
    end
    checks++;
    if (tog_err !== 0) begin
      errors++;
      $display("FAIL fast_m2_toggle: got %0d stuck clks want 0", tog_err);
    end
    pat_err = (rwq.size() == 10) ? 0 : 1;
    foreach (rwq[i]) if (rwq[i] !== ((i % 2) == 0)) pat_err++;
    checks++;
    if (pat_err !== 0 || werr !== 0) begin
      errors++;
      $display("FAIL fast_rw_pattern: got %0d cycles, %0d pattern and %0d data errors want 10 0 0",
               rwq.size(), pat_err, werr);
    end
  endtask

  task automatic test_shadow();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1;
    shadow_reset_model();
    mon_q.delete();
    run_cmd(2'd2, 5'h15, 1'b1, 1'b0, 5'($urandom));
    checks++;
    if (r_to || r_serr !== 0) begin
      errors++;
      $display("FAIL shadow_cmd: got timeout=%0d bad=%0d want 0 0", r_to, r_serr);
    end
    for (int i = 0; i < 4; i++) begin
      ifa.sh_sel = 2'(i);
      #1;
      checks++;
`ifdef MMC1W_SHADOW_EN
      if (ifa.sh_dat !== exp_sh[i]) begin
        errors++;
        $display("FAIL shadow_read[%0d]: got %h want %h", i, ifa.sh_dat, exp_sh[i]);
      end
`else
      if (ifa.sh_dat !== 5'd0) begin
        errors++;
        $display("FAIL shadow_off[%0d]: got %h want 00", i, ifa.sh_dat);
      end
`endif
    end
  endtask

  task automatic test_integrity();
    checks++;
    if (consec !== 0) begin
      errors++;
      $display("FAIL write_after_write: got %0d want 0", consec);
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL bus_stable: got %0d mid-cycle changes want 0", unstable);
    end
  endtask

  initial begin
    ifa.cmd_valid = 1'b0; ifa.cmd_reg = 2'd0; ifa.cmd_data = 5'd0; ifa.cmd_rst = 1'b0; ifa.sh_sel = 2'd0;
    ifb.cmd_valid = 1'b0; ifb.cmd_reg = 2'd0; ifb.cmd_data = 5'd0; ifb.cmd_rst = 1'b0; ifb.sh_sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      rx_reg[i] = 5'd0;
      exp_rx[i] = 5'd0;
    end
    rx_sr = 5'd0; rx_cnt = 0; rx_prev_w = 1'b0;
    consec = 0; unstable = 0;
    shadow_reset_model();

    test_reset();
    test_sequence();
    test_receiver();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_fast();
    test_shadow();
    test_integrity();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
